// File: rtl/idma_sched_pkg.sv
// Shared types and constants for the iDMA read-request scheduler.
package idma_sched_pkg;

  localparam int unsigned TRK_DEPTH_DEF = 8;
  localparam int unsigned TRK_ID_W      = 3;   // wide enough for up to 8 clients
  localparam int unsigned TRK_NUM_W     = 32;

  // Tracker entry: owning client and descriptor length in 256b words
  typedef struct packed {
    logic [TRK_ID_W-1:0]  id;
    logic [TRK_NUM_W-1:0] num;
  } trk_entry_t;

  localparam int unsigned TRK_ENTRY_W = $bits(trk_entry_t);

  // Error bit positions in the status CSR
  localparam int unsigned ERR_ZERO_LEN_BIT = 0;
  localparam int unsigned ERR_ORPHAN_BIT   = 1;

endpackage

// File: rtl/idma_rr_arb.sv
// Round-robin arbiter: first request at or after the pointer wins; pointer
// advances past the winner on every grant.
module idma_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               clr,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_idx
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW:0]   scan;
  logic           found;

  // Wrapping upward scan from the pointer
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      if (!found && req[scan[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && found) gnt[gnt_idx] = 1'b1;
    ptr_nxt = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clr) ptr <= '0;
    else if (|gnt)       ptr <= ptr_nxt;
  end

endmodule

// File: rtl/idma_rd_req_sched.sv
// Shares one 256b iDMA read channel among NUM_REQ clients: round-robin issue
// into the address FIFO, in-order steering of returned data to its owner.
module idma_rd_req_sched
  import idma_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned REQ_IDW      = 2,
  parameter int unsigned AXI_ADDR_WID = 32,
  parameter int unsigned TRK_DEPTH    = TRK_DEPTH_DEF,
  parameter int unsigned TRK_CNT_WID  = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            sched_init,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*AXI_ADDR_WID-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]           req_num,
  output logic                            rd_req,
  output logic [AXI_ADDR_WID-1:0]         rd_addr,
  output logic [31:0]                     rd_num,
  input  logic                            rd_addr_ready,
  input  logic                            rd_data_valid,
  output logic                            rd_data_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic                            rsp_last,
  output logic                            busy,
  output logic [TRK_CNT_WID-1:0]          trk_word_cnt,
  output logic                            err_zero_len,
  output logic                            err_orphan
);

  localparam int unsigned PTR_W = $clog2(TRK_DEPTH);

  logic [NUM_REQ-1:0]      gnt;
  logic [REQ_IDW-1:0]      gnt_idx;
  logic                    issue_en;
  logic                    accept;
  logic                    zero_len;
  logic [AXI_ADDR_WID-1:0] sel_addr;
  logic [31:0]             sel_num;

  trk_entry_t              trk_mem [TRK_DEPTH];
  trk_entry_t              push_ent;
  trk_entry_t              head;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [TRK_CNT_WID-1:0]  trk_cnt;
  logic                    trk_empty;
  logic                    trk_full;
  logic                    push;
  logic                    pop;
  logic                    beat;
  logic [31:0]             bcnt;
  logic [NUM_REQ-1:0]      hid_oh;

  assign trk_empty = (trk_cnt == '0);
  assign trk_full  = (trk_cnt == TRK_CNT_WID'(TRK_DEPTH));
  assign issue_en  = aresetn & rd_addr_ready & ~trk_full & ~sched_init;

  idma_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (REQ_IDW)
  ) u_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (sched_init),
    .req     (req_valid),
    .en      (issue_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Descriptor select from the one-hot grant
  always_comb begin
    sel_addr = '0;
    sel_num  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AXI_ADDR_WID +: AXI_ADDR_WID];
        sel_num  = req_num[i*32 +: 32];
      end
    end
  end

  assign accept       = |gnt;
  assign zero_len     = (sel_num == 32'd0);
  assign req_ready    = gnt;
  assign rd_req       = accept & ~zero_len;
  assign rd_addr      = sel_addr;
  assign rd_num       = sel_num;
  assign err_zero_len = accept & zero_len;

  assign push         = rd_req;
  assign push_ent.id  = TRK_ID_W'(gnt_idx);
  assign push_ent.num = sel_num;
  assign head         = trk_mem[rd_ptr];

  always_comb begin
    hid_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hid_oh[i] = (head.id == TRK_ID_W'(i));
    end
  end

  assign rsp_valid     = (rd_data_valid && !trk_empty) ? hid_oh : '0;
  assign rd_data_ready = ~trk_empty & |(rsp_ready & hid_oh);
  assign rsp_last      = ~trk_empty & (bcnt == head.num - 32'd1);
  assign beat          = rd_data_valid & rd_data_ready;
  assign pop           = beat & rsp_last;
  assign busy          = ~trk_empty;
  assign trk_word_cnt  = trk_cnt;

  // Tracker storage needs no reset: entries are only read while counted valid
  always_ff @(posedge aclk) begin
    if (push) trk_mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || sched_init) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trk_cnt    <= '0;
      bcnt       <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   trk_cnt <= trk_cnt + TRK_CNT_WID'(1);
        2'b01:   trk_cnt <= trk_cnt - TRK_CNT_WID'(1);
        default: trk_cnt <= trk_cnt;
      endcase
      if (beat) bcnt <= rsp_last ? 32'd0 : bcnt + 32'd1;
      if (rd_data_valid && trk_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_idma_rd_req_sched.sv
// Bench for idma_rd_req_sched: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_idma_rd_req_sched;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         sched_init;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_addr;
  logic [127:0] req_num;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic [31:0]  rd_num;
  logic         rd_addr_ready;
  logic         rd_data_valid;
  logic         rd_data_ready;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic         rsp_last;
  logic         busy;
  logic [3:0]   trk_word_cnt;
  logic         err_zero_len;
  logic         err_orphan;

  always #5 aclk = ~aclk;

  idma_rd_req_sched dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .sched_init    (sched_init),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_num       (req_num),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_num        (rd_num),
    .rd_addr_ready (rd_addr_ready),
    .rd_data_valid (rd_data_valid),
    .rd_data_ready (rd_data_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_last      (rsp_last),
    .busy          (busy),
    .trk_word_cnt  (trk_word_cnt),
    .err_zero_len  (err_zero_len),
    .err_orphan    (err_orphan)
  );

  typedef struct {
    int          id;
    int unsigned num;
  } ent_t;

  // Reference model state: in-flight descriptors in issue order
  ent_t        mq[$];
  int unsigned m_bcnt = 0;
  int          m_ptr  = 0;
  bit          m_orph = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]  s_rr, s_rv;
  logic        s_rq, s_last, s_busy, s_zl, s_dr, s_orph;
  logic [31:0] s_addr, s_num;
  logic [3:0]  s_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    sched_init    = 1'b0;
    req_valid     = '0;
    req_addr      = '0;
    req_num       = '0;
    rd_addr_ready = 1'b1;
    rd_data_valid = 1'b0;
    rsp_ready     = '0;
  endtask

  // One clock: check outputs against the model, snapshot, advance the model
  task automatic step();
    int          g;
    int          j;
    int unsigned gnum;
    bit          en, empty, e_rq, e_zl, e_dr, e_last;
    logic [3:0]  e_rr, e_rv;
    int          hid;
    #1;
    en = aresetn && rd_addr_ready && (mq.size() < 8) && !sched_init;
    g  = -1;
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    e_rr = (g >= 0) ? 4'(1 << g) : 4'd0;
    gnum = (g >= 0) ? req_num[g*32 +: 32] : 0;
    e_rq = (g >= 0) && (gnum != 0);
    e_zl = (g >= 0) && (gnum == 0);
    empty  = (mq.size() == 0);
    hid    = empty ? 0 : mq[0].id;
    e_rv   = (!empty && rd_data_valid) ? 4'(1 << hid) : 4'd0;
    e_dr   = !empty && rsp_ready[hid];
    e_last = !empty && (m_bcnt == mq[0].num - 1);

    chk("req_ready",     64'(req_ready),     64'(e_rr));
    chk("rd_req",        64'(rd_req),        64'(e_rq));
    chk("err_zero_len",  64'(err_zero_len),  64'(e_zl));
    chk("rsp_valid",     64'(rsp_valid),     64'(e_rv));
    chk("rd_data_ready", 64'(rd_data_ready), 64'(e_dr));
    chk("rsp_last",      64'(rsp_last),      64'(e_last));
    chk("busy",          64'(busy),          64'(!empty));
    chk("trk_word_cnt",  64'(trk_word_cnt),  64'(mq.size()));
    chk("err_orphan",    64'(err_orphan),    64'(m_orph));
    if (e_rq) begin
      chk("rd_addr", 64'(rd_addr), 64'(req_addr[g*32 +: 32]));
      chk("rd_num",  64'(rd_num),  64'(gnum));
    end

    s_rr = req_ready; s_rq = rd_req; s_addr = rd_addr; s_num = rd_num;
    s_rv = rsp_valid; s_last = rsp_last; s_busy = busy; s_cnt = trk_word_cnt;
    s_zl = err_zero_len; s_dr = rd_data_ready; s_orph = err_orphan;

    if (!aresetn || sched_init) begin
      mq.delete();
      m_bcnt = 0;
      m_ptr  = 0;
      m_orph = 1'b0;
    end else begin
      if (rd_data_valid && e_dr) begin
        if (e_last) begin
          void'(mq.pop_front());
          m_bcnt = 0;
        end else begin
          m_bcnt++;
        end
      end
      if (rd_data_valid && empty) m_orph = 1'b1;
      if (e_rq) mq.push_back('{g, gnum});
      if (g >= 0) m_ptr = (g + 1) % 4;
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic pulse_init();
    idle();
    sched_init = 1'b1;
    step();
    sched_init = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid     = '0;
    rd_data_valid = 1'b1;
    rsp_ready     = 4'hf;
    repeat (n) step();
    rd_data_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] fair_acc [5];
    logic [3:0] fair_rv  [10];
    int         acc;
    bit         got;
    fair_acc = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    fair_rv  = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1};

    idle();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // Reset state
    step();
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_cnt",  64'(s_cnt),  64'd0);
    chk("rst_orph", 64'(s_orph), 64'd0);

    // Single client, 4 beats
    req_valid = 4'b0001;
    req_addr[31:0] = 32'h1000;
    req_num[31:0]  = 32'd4;
    step();
    chk("single_acc",  64'(s_rr),   64'h1);
    chk("single_rq",   64'(s_rq),   64'd1);
    chk("single_addr", 64'(s_addr), 64'h1000);
    chk("single_num",  64'(s_num),  64'd4);
    req_valid = '0;
    rd_data_valid = 1'b1;
    rsp_ready = 4'hf;
    for (int b = 0; b < 4; b++) begin
      step();
      chk("single_rv",   64'(s_rv),   64'h1);
      chk("single_last", 64'(s_last), 64'(b == 3));
    end
    rd_data_valid = 1'b0;
    step();
    chk("single_busy_drop", 64'(s_busy), 64'd0);

    // Fairness
    pulse_init();
    req_valid = 4'hf;
    for (int i = 0; i < 4; i++) req_num[i*32 +: 32] = 32'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fair_order", 64'(s_rr), 64'(fair_acc[i]));
    end
    req_valid = '0;
    rd_data_valid = 1'b1;
    rsp_ready = 4'hf;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("fair_owner", 64'(s_rv), 64'(fair_rv[i]));
    end
    rd_data_valid = 1'b0;

    // Tracker full
    pulse_init();
    req_valid = 4'b0010;
    req_num[63:32] = 32'd1;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (s_rr != 0) acc++;
    end
    chk("full_accepts", 64'(acc), 64'd8);
    chk("full_blocked", 64'(s_rr), 64'd0);
    chk("full_cnt",     64'(s_cnt), 64'd8);
    rd_data_valid = 1'b1;
    rsp_ready = 4'hf;
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      step();
      if (s_rr == 4'b0010) got = 1'b1;
    end
    chk("full_ninth_accepted", 64'(got), 64'd1);
    drain(8);

    // Address backpressure and response backpressure
    pulse_init();
    req_valid = 4'b1000;
    req_num[127:96] = 32'd3;
    step();
    req_valid = 4'hf;
    for (int i = 0; i < 3; i++) req_num[i*32 +: 32] = 32'd2;
    rd_addr_ready = 1'b0;
    rd_data_valid = 1'b1;
    rsp_ready = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_no_accept", 64'(s_rr), 64'd0);
      chk("bp_no_rdreq",  64'(s_rq), 64'd0);
      chk("bp_no_pop",    64'(s_dr), 64'd0);
      chk("bp_rv_held",   64'(s_rv), 64'h8);
    end
    rd_addr_ready = 1'b1;
    rd_data_valid = 1'b0;
    step();
    chk("bp_ptr_held", 64'(s_rr), 64'h1);
    drain(5);

    // Zero-length descriptor
    pulse_init();
    req_valid = 4'b0100;
    req_num[95:64] = 32'd0;
    step();
    chk("zl_accept", 64'(s_rr), 64'h4);
    chk("zl_pulse",  64'(s_zl), 64'd1);
    chk("zl_no_rq",  64'(s_rq), 64'd0);
    req_valid = '0;
    step();
    chk("zl_pulse_once", 64'(s_zl),  64'd0);
    chk("zl_cnt",        64'(s_cnt), 64'd0);
    req_valid = 4'hf;
    for (int i = 0; i < 4; i++) req_num[i*32 +: 32] = 32'd2;
    step();
    chk("zl_ptr_to_3", 64'(s_rr), 64'h8);
    drain(2);

    // Clear mid-transfer, orphan data, reset clears orphan
    pulse_init();
    req_valid = 4'b0001;
    req_num[31:0] = 32'd8;
    step();
    req_valid = '0;
    rd_data_valid = 1'b1;
    rsp_ready = 4'hf;
    repeat (3) step();
    rd_data_valid = 1'b0;
    sched_init = 1'b1;
    step();
    sched_init = 1'b0;
    step();
    chk("clr_cnt",  64'(s_cnt),  64'd0);
    chk("clr_busy", 64'(s_busy), 64'd0);
    rd_data_valid = 1'b1;
    step();
    chk("orph_no_pop", 64'(s_dr), 64'd0);
    step();
    chk("orph_set", 64'(s_orph), 64'd1);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    chk("orph_rst_clr", 64'(s_orph), 64'd0);
    rd_data_valid = 1'b0;

    // Randomized traffic
    pulse_init();
    for (int c = 0; c < 3000; c++) begin
      req_valid     = 4'($urandom_range(0, 15));
      rd_addr_ready = ($urandom_range(0, 3) != 0);
      rd_data_valid = ($urandom_range(0, 4) < 3);
      rsp_ready     = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      sched_init    = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        req_addr[i*32 +: 32] = $urandom;
        req_num[i*32 +: 32]  = $urandom_range(0, 5);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
